// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module   : pipeline_pkg
// Brief    : Shared RV32I opcode, immediate-format and ID-stage FSM encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] OP     = 7'b0110011;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam int FLUSH_CNT_W = 3;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } id_state_e;

endpackage

`default_nettype wire

// File: rtl/id_fmt_decode.sv
// ============================================================================
// Module   : id_fmt_decode
// Brief    : Opcode to immediate format / register-use / legality decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_fmt_decode
  import pipeline_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic [2:0] o_imm_fmt,
  output logic       o_uses_rs1,
  output logic       o_uses_rs2,
  output logic       o_illegal
);

  always_comb begin
    o_imm_fmt = FMT_ILL;
    case (i_opcode)
      OP_IMM, LOAD, JALR: o_imm_fmt = FMT_I;
      STORE:              o_imm_fmt = FMT_S;
      BRANCH:             o_imm_fmt = FMT_B;
      LUI, AUIPC:         o_imm_fmt = FMT_U;
      JAL:                o_imm_fmt = FMT_J;
      OP:                 o_imm_fmt = FMT_R;
      default:            o_imm_fmt = FMT_ILL;
    endcase
  end

  assign o_illegal  = (o_imm_fmt == FMT_ILL);
  assign o_uses_rs1 = !((o_imm_fmt == FMT_U) || (o_imm_fmt == FMT_J) || (o_imm_fmt == FMT_ILL));
  assign o_uses_rs2 = (o_imm_fmt == FMT_R) || (o_imm_fmt == FMT_S) || (o_imm_fmt == FMT_B);

endmodule

`default_nettype wire

// File: rtl/id_stage_ctrl.sv
// ============================================================================
// Module   : id_stage_ctrl
// Brief    : RV32I decode-stage controller: IF/ID register, load-use stall,
//            redirect flush. Optional perf counters under ID_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage_ctrl
  import pipeline_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_ready,
  input  logic            id_ready,
  input  logic            ex_valid,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic            ex_redirect,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_imm_fmt,
  output logic            id_illegal,
  output logic            id_issue,
  output logic            id_bubble
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] c_flush_init =
    FLUSH_CNT_W'((FLUSH_CYCLES > 0) ? (FLUSH_CYCLES - 1) : 0);

  id_state_e              r_state;
  id_state_e              w_state_nxt;
  logic [FLUSH_CNT_W-1:0] r_flush_cnt;
  logic [FLUSH_CNT_W-1:0] w_flush_cnt_nxt;
  logic                   r_valid;
  logic [XLEN-1:0]        r_instr;
  logic [XLEN-1:0]        r_pc;
  logic [2:0]             w_fmt;
  logic                   w_uses_rs1;
  logic                   w_uses_rs2;
  logic                   w_illegal;
  logic                   w_hz;
  logic                   w_load;

  id_fmt_decode u_fmt_decode (
    .i_opcode   (r_instr[6:0]),
    .o_imm_fmt  (w_fmt),
    .o_uses_rs1 (w_uses_rs1),
    .o_uses_rs2 (w_uses_rs2),
    .o_illegal  (w_illegal)
  );

  // Load-use: the EX load's result is not forwardable in time for a source here.
  assign w_hz = r_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                ((w_uses_rs1 & (ex_rd == r_instr[19:15])) |
                 (w_uses_rs2 & (ex_rd == r_instr[24:20])));

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    id_issue        = r_valid & ~w_hz & id_ready & ~ex_redirect;
    id_bubble       = w_hz & ~ex_redirect;
    if_ready        = 1'b0;
    w_load          = 1'b0;
    case (r_state)
      ST_RUN: begin
        if_ready = ~ex_redirect & (~r_valid | id_issue);
        w_load   = if_valid & if_ready;
        if (ex_redirect && (FLUSH_CYCLES > 0)) begin
          w_state_nxt     = ST_FLUSH;
          w_flush_cnt_nxt = c_flush_init;
        end
      end
      ST_FLUSH: begin
        // Wrong-path fetch data is consumed and dropped.
        if_ready = 1'b1;
        if (ex_redirect) begin
          w_flush_cnt_nxt = c_flush_init;
        end else if (r_flush_cnt == '0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - FLUSH_CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (ex_redirect) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_instr <= if_instr;
      r_pc    <= if_pc;
    end else if (id_issue) begin
      r_valid <= 1'b0;
    end
  end

  assign id_valid   = r_valid;
  assign id_instr   = r_instr;
  assign id_pc      = r_pc;
  assign id_opcode  = r_instr[6:0];
  assign id_imm_fmt = w_fmt;
  assign id_illegal = r_valid & w_illegal;

`ifdef ID_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_evt_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt     <= '0;
      r_flush_evt_cnt <= '0;
    end else begin
      if (id_bubble && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (ex_redirect && (r_flush_evt_cnt != 32'hFFFF_FFFF)) begin
        r_flush_evt_cnt <= r_flush_evt_cnt + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_evt_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_stage_ctrl.sv
// ============================================================================
// Module   : tb_id_stage_ctrl
// Brief    : Self-checking bench for id_stage_ctrl (FLUSH_CYCLES=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_id_stage_ctrl;

  localparam int XLEN         = 32;
  localparam int FLUSH_CYCLES = 2;

  localparam logic [31:0] c_addi = 32'h0050_0093;
  localparam logic [31:0] c_sw   = 32'h0020_A023;
  localparam logic [31:0] c_add  = 32'h0072_8333;
  localparam logic [31:0] c_ill  = 32'h0000_007F;
  localparam logic [31:0] c_x1   = 32'h0010_0093;
  localparam logic [31:0] c_x2   = 32'h0020_0113;
  localparam logic [31:0] c_x3   = 32'h0030_0193;
  localparam logic [31:0] c_x4   = 32'h0040_0213;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            if_valid, if_ready, id_ready;
  logic [XLEN-1:0] if_instr, if_pc;
  logic            ex_valid, ex_mem_read, ex_redirect;
  logic [4:0]      ex_rd;
  logic            id_valid, id_illegal, id_issue, id_bubble;
  logic [XLEN-1:0] id_instr, id_pc;
  logic [6:0]      id_opcode;
  logic [2:0]      id_imm_fmt;
`ifdef ID_PERF_CNT_EN
  logic [31:0]     perf_stall_cnt, perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  id_stage_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_ready    (if_ready),
    .id_ready    (id_ready),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .ex_redirect (ex_redirect),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_opcode   (id_opcode),
    .id_imm_fmt  (id_imm_fmt),
    .id_illegal  (id_illegal),
    .id_issue    (id_issue),
    .id_bubble   (id_bubble)
`ifdef ID_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        exv, exm;
    logic [4:0]  rd;
    logic        rdy;
    logic [2:0]  fmt;
    logic        ill, bub, iss, ifr;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } sb_t;

  vec_t vt[$];
  sb_t  sbq[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_valid = 1'b0; if_instr = '0; if_pc = '0; id_ready = 1'b0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = '0; ex_redirect = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic sb_pop(input string tag);
    sb_t e;
    if (sbq.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s_sb_empty: got issue=1 with pc %0h expected no issue", tag, id_pc);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_instr"}, id_instr, e.instr);
      chk({tag, "_pc"}, id_pc, e.pc);
    end
  endtask

  task automatic add_vec(input string n, input logic [31:0] ins, input logic exv, input logic exm,
                         input logic [4:0] rd, input logic rdy, input logic [2:0] fmt,
                         input logic ill, input logic bub, input logic iss, input logic ifr);
    vec_t v;
    v.name = n; v.instr = ins; v.exv = exv; v.exm = exm; v.rd = rd; v.rdy = rdy;
    v.fmt = fmt; v.ill = ill; v.bub = bub; v.iss = iss; v.ifr = ifr;
    vt.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic m_valid, exp_issue, exp_ifr;
    sb_t  e;

    //            name          instr          exv  exm  rd  rdy fmt ill bub iss ifr
    add_vec("addi",        c_addi,        0, 0, 0, 1, 1, 0, 0, 1, 1);
    add_vec("sw",          c_sw,          0, 0, 0, 1, 2, 0, 0, 1, 1);
    add_vec("add_rs1_hz",  c_add,         1, 1, 5, 1, 0, 0, 1, 0, 0);
    add_vec("add_rs2_hz",  c_add,         1, 1, 7, 1, 0, 0, 1, 0, 0);
    add_vec("add_rd0",     c_add,         1, 1, 0, 1, 0, 0, 0, 1, 1);
    add_vec("add_noload",  c_add,         1, 0, 5, 1, 0, 0, 0, 1, 1);
    add_vec("add_exinv",   c_add,         0, 1, 5, 1, 0, 0, 0, 1, 1);
    add_vec("add_rdmatch", c_add,         1, 1, 6, 1, 0, 0, 0, 1, 1);
    add_vec("lui_nors1",   32'h0003_0337, 1, 1, 6, 1, 4, 0, 0, 1, 1);
    add_vec("sw_rs2_hz",   c_sw,          1, 1, 2, 1, 2, 0, 1, 0, 0);
    add_vec("beq_hz",      32'h0020_8463, 1, 1, 1, 1, 3, 0, 1, 0, 0);
    add_vec("lw_hz",       32'h0000_A103, 1, 1, 1, 1, 1, 0, 1, 0, 0);
    add_vec("jal_nors1",   32'h0000_80EF, 1, 1, 1, 1, 5, 0, 0, 1, 1);
    add_vec("jalr_hz",     32'h0000_8067, 1, 1, 1, 1, 1, 0, 1, 0, 0);
    add_vec("addi_nors2",  c_addi,        1, 1, 5, 1, 1, 0, 0, 1, 1);
    add_vec("auipc",       32'h0000_0097, 1, 1, 1, 1, 4, 0, 0, 1, 1);
    add_vec("illegal",     c_ill,         0, 0, 0, 1, 7, 1, 0, 1, 1);
    add_vec("ill_nors1",   32'h0000_807F, 1, 1, 1, 1, 7, 1, 0, 1, 1);
    add_vec("addi_bp",     c_addi,        0, 0, 0, 0, 1, 0, 0, 0, 0);

    // Reset state
    do_reset();
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_instr", id_instr, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_issue", id_issue, 0);
    chk("rst_id_bubble", id_bubble, 0);
    chk("rst_id_illegal", id_illegal, 0);
    chk("rst_if_ready", if_ready, 1);
    chk("rst_imm_fmt", id_imm_fmt, 7);

    // Table-driven decode / hazard vectors
    foreach (vt[i]) begin
      do_reset();
      if_valid = 1'b1; if_instr = vt[i].instr; if_pc = 32'h100 + 32'(i * 4);
      step();
      if_valid = 1'b0; ex_valid = vt[i].exv; ex_mem_read = vt[i].exm;
      ex_rd = vt[i].rd; id_ready = vt[i].rdy;
      #1;
      chk({vt[i].name, "_valid"}, id_valid, 1);
      chk({vt[i].name, "_opcode"}, id_opcode, vt[i].instr & 32'h7F);
      chk({vt[i].name, "_fmt"}, id_imm_fmt, vt[i].fmt);
      chk({vt[i].name, "_illegal"}, id_illegal, vt[i].ill);
      chk({vt[i].name, "_bubble"}, id_bubble, vt[i].bub);
      chk({vt[i].name, "_issue"}, id_issue, vt[i].iss);
      chk({vt[i].name, "_if_ready"}, if_ready, vt[i].ifr);
    end

    // Streaming addi then sw
    do_reset();
    sbq.delete();
    id_ready = 1'b1; if_valid = 1'b1; if_instr = c_addi; if_pc = 32'h0;
    #1;
    chk("stream_if_ready", if_ready, 1);
    e.instr = c_addi; e.pc = 32'h0; sbq.push_back(e);
    step();
    if_instr = c_sw; if_pc = 32'h4;
    #1;
    chk("stream_c1_valid", id_valid, 1);
    chk("stream_c1_fmt", id_imm_fmt, 1);
    chk("stream_c1_issue", id_issue, 1);
    chk("stream_c1_if_ready", if_ready, 1);
    if (id_issue) sb_pop("stream");
    e.instr = c_sw; e.pc = 32'h4; sbq.push_back(e);
    step();
    if_valid = 1'b0;
    #1;
    chk("stream_c2_valid", id_valid, 1);
    chk("stream_c2_fmt", id_imm_fmt, 2);
    chk("stream_c2_issue", id_issue, 1);
    if (id_issue) sb_pop("stream");
    step();
    chk("stream_drained", id_valid, 0);
    chk("stream_sb_left", sbq.size(), 0);

    // Random stream with backpressure against a reference model
    do_reset();
    sbq.delete();
    m_valid = 1'b0;
    for (int c = 0; c < 60; c++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      if_valid = $urandom_range(0, 1) != 0;
      if_instr = $urandom;
      if_pc    = 32'h1000 + 32'(c * 4);
      #1;
      exp_issue = m_valid & id_ready;
      exp_ifr   = ~m_valid | exp_issue;
      chk("rnd_if_ready", if_ready, exp_ifr);
      chk("rnd_issue", id_issue, exp_issue);
      if (id_issue) sb_pop("rnd");
      if (if_valid && exp_ifr) begin
        e.instr = if_instr; e.pc = if_pc; sbq.push_back(e);
      end
      m_valid = (if_valid && exp_ifr) ? 1'b1 : (exp_issue ? 1'b0 : m_valid);
      step();
    end
    if_valid = 1'b0; id_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (id_issue) sb_pop("rnd_drain");
      step();
    end
    chk("rnd_sb_left", sbq.size(), 0);

    // Load-use stall for 4 cycles, release, then one redirect
    do_reset();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_ready = 1'b1;
    if_valid = 1'b1; if_instr = c_add; if_pc = 32'h40;
    #1;
    chk("lu_if_ready_empty", if_ready, 1);
    step();
    if_instr = c_sw; if_pc = 32'h44;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("lu_bubble", id_bubble, 1);
      chk("lu_issue", id_issue, 0);
      chk("lu_if_ready", if_ready, 0);
      chk("lu_hold_instr", id_instr, c_add);
      step();
    end
    ex_mem_read = 1'b0;
    #1;
    chk("lu_release_issue", id_issue, 1);
    chk("lu_release_bubble", id_bubble, 0);
    chk("lu_release_if_ready", if_ready, 1);
    step();
    if_valid = 1'b0; ex_redirect = 1'b1;
    #1;
    chk("lu_redir_issue", id_issue, 0);
    chk("lu_redir_if_ready", if_ready, 0);
    step();
    ex_redirect = 1'b0;
    #1;
    chk("lu_redir_kill", id_valid, 0);
`ifdef ID_PERF_CNT_EN
    chk("perf_stall_cnt", perf_stall_cnt, 4);
    chk("perf_flush_cnt", perf_flush_cnt, 1);
`endif
    step(); step(); step();

    // Redirect flush window, including a restart from inside FLUSH
    do_reset();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_ready = 1'b1;
    if_valid = 1'b1; if_instr = c_add; if_pc = 32'h80;
    step();
    if_instr = 32'h0010_0013;
    #1;
    chk("fl_pre_bubble", id_bubble, 1);
    step();
    ex_redirect = 1'b1;
    #1;
    chk("fl_bubble_suppressed", id_bubble, 0);
    chk("fl_redir_issue", id_issue, 0);
    chk("fl_redir_if_ready", if_ready, 0);
    step();
    ex_redirect = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0;
    if_instr = c_x1; if_pc = 32'h90;
    #1;
    chk("fl_f1_valid", id_valid, 0);
    chk("fl_f1_if_ready", if_ready, 1);
    step();
    if_instr = c_x2; if_pc = 32'h94;
    #1;
    chk("fl_f2_valid", id_valid, 0);
    chk("fl_f2_if_ready", if_ready, 1);
    step();
    if_instr = c_x3; if_pc = 32'h98;
    #1;
    chk("fl_f3_valid", id_valid, 0);
    chk("fl_f3_if_ready", if_ready, 1);
    step();
    ex_redirect = 1'b1; if_valid = 1'b0;
    #1;
    chk("fl_load_instr", id_instr, c_x3);
    chk("fl_load_pc", id_pc, 32'h98);
    chk("fl_load_issue_killed", id_issue, 0);
    step();
    if_valid = 1'b1; if_instr = c_x1;
    #1;
    chk("fl_r1_valid", id_valid, 0);
    chk("fl_r1_if_ready", if_ready, 1);
    step();
    ex_redirect = 1'b0; if_instr = c_x2;
    #1;
    chk("fl_r2_valid", id_valid, 0);
    step();
    if_instr = c_x3;
    #1;
    chk("fl_r3_valid", id_valid, 0);
    step();
    if_instr = c_x4; if_pc = 32'hA0;
    #1;
    chk("fl_restart_window", id_valid, 0);
    step();
    if_valid = 1'b0;
    #1;
    chk("fl_r_load_valid", id_valid, 1);
    chk("fl_r_load_instr", id_instr, c_x4);

    // Backpressure then illegal opcode
    do_reset();
    if_valid = 1'b1; if_instr = c_addi; if_pc = 32'h200;
    step();
    if_instr = c_sw; if_pc = 32'h204;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_instr_stable", id_instr, c_addi);
      chk("bp_pc_stable", id_pc, 32'h200);
      chk("bp_if_ready", if_ready, 0);
      chk("bp_issue", id_issue, 0);
      step();
    end
    id_ready = 1'b1;
    #1;
    chk("bp_release_issue", id_issue, 1);
    chk("bp_release_if_ready", if_ready, 1);
    step();
    if_instr = c_ill; if_pc = 32'h208;
    #1;
    chk("bp_next_instr", id_instr, c_sw);
    step();
    if_valid = 1'b0;
    #1;
    chk("ill_fmt", id_imm_fmt, 7);
    chk("ill_flag", id_illegal, 1);
    chk("ill_issue", id_issue, 1);

    // Mid-operation reset, with valid data and then inside FLUSH
    do_reset();
    if_valid = 1'b1; if_instr = c_x1; if_pc = 32'h300;
    step();
    if_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mrst_valid", id_valid, 0);
    chk("mrst_instr", id_instr, 0);
    chk("mrst_pc", id_pc, 0);
    ex_redirect = 1'b1;
    step();
    ex_redirect = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; if_valid = 1'b1; if_instr = c_x2; if_pc = 32'h304;
    #1;
    chk("frst_valid", id_valid, 0);
    chk("frst_issue", id_issue, 0);
    chk("frst_bubble", id_bubble, 0);
    chk("frst_illegal", id_illegal, 0);
    chk("frst_if_ready", if_ready, 1);
    step();
    if_valid = 1'b0;
    #1;
    chk("frst_run_load_valid", id_valid, 1);
    chk("frst_run_load_instr", id_instr, c_x2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
